// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared encodings and sizes for gate-level BIST controllers
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } bist_state_e;

    localparam int N_VEC = 4;
    localparam int VEC_W = 2;
    localparam int CNT_W = 4;
    localparam int ERR_W = 3;

endpackage

// File: rtl/and2.sv
// rtl/and2.sv - two-input AND gate exercised by the BIST controller
module and2 (
    input  logic in1,
    input  logic in2,
    output logic Out
);

    assign Out = in1 & in2;

endmodule

// File: rtl/and2_bist_ctrl.sv
// rtl/and2_bist_ctrl.sv - exhaustive self-test sequencer for a two-input AND gate
module and2_bist_ctrl
    import bist_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dut_out,
    output logic             dut_a,
    output logic             dut_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [N_VEC-1:0] fail_vec
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(N_VEC - 1);

    bist_state_e      state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dut_a_q, dut_a_d;
    logic             dut_b_q, dut_b_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [N_VEC-1:0] fail_q, fail_d;
    logic             pass_q, pass_d;

    logic             mismatch;
    logic [ERR_W-1:0] err_nxt;
    logic [N_VEC-1:0] fail_nxt;
    logic [VEC_W-1:0] vec_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            dut_a_q <= 1'b0;
            dut_b_q <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            dut_a_q <= dut_a_d;
            dut_b_q <= dut_b_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_SETTLE;
            ST_SETTLE: if (cnt_q == '0) state_d = ST_CHECK;
            ST_CHECK:  state_d = (vec_q == LAST_VEC) ? ST_DONE : ST_SETTLE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // The gate is compared against the vector it is actually being driven with.
    assign mismatch = dut_out != (dut_a_q & dut_b_q);
    assign err_nxt  = err_q + {{(ERR_W-1){1'b0}}, mismatch};
    assign fail_nxt = fail_q | (N_VEC'(mismatch) << vec_q);
    assign vec_inc  = vec_q + 1'b1;

    always_comb begin
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        dut_a_d = dut_a_q;
        dut_b_d = dut_b_q;
        err_d   = err_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        case (state_q)
            ST_IDLE: begin
                dut_a_d = 1'b0;
                dut_b_d = 1'b0;
                if (start) begin
                    vec_d  = '0;
                    cnt_d  = SETTLE_LOAD;
                    err_d  = '0;
                    fail_d = '0;
                    pass_d = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end
            ST_CHECK: begin
                err_d  = err_nxt;
                fail_d = fail_nxt;
                if (vec_q == LAST_VEC) begin
                    dut_a_d = 1'b0;
                    dut_b_d = 1'b0;
                    pass_d  = (err_nxt == '0);
                end else begin
                    vec_d   = vec_inc;
                    cnt_d   = SETTLE_LOAD;
                    dut_a_d = vec_inc[1];
                    dut_b_d = vec_inc[0];
                end
            end
            ST_DONE: begin
                dut_a_d = 1'b0;
                dut_b_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
        done      = (state_q == ST_DONE);
        dut_a     = dut_a_q;
        dut_b     = dut_b_q;
        pass      = pass_q;
        err_count = err_q;
        fail_vec  = fail_q;
    end

endmodule

// File: tb/tb_and2_bist_ctrl.sv
// tb/tb_and2_bist_ctrl.sv - directed self-checking bench for and2_bist_ctrl
module tb_and2_bist_ctrl;
    import bist_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start0, start1;
    logic [1:0] mode;
    logic stuck0;
    logic and_out, dut_out0;
    logic a0, b0, busy0, done0, pass0;
    logic a1, b1, busy1, done1, pass1;
    logic [ERR_W-1:0] err0, err1;
    logic [N_VEC-1:0] fail0, fail1;

    int checks = 0;
    int errors = 0;

    and2 u_gate (.in1(a0), .in2(b0), .Out(and_out));

    always_comb begin
        case (mode)
            2'd0:    dut_out0 = and_out;
            2'd1:    dut_out0 = 1'b1;
            2'd2:    dut_out0 = a0 | b0;
            default: dut_out0 = 1'b0;
        endcase
    end

    and2_bist_ctrl #(.SETTLE_CYC(2)) u_ctrl0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .dut_out(dut_out0),
        .dut_a(a0), .dut_b(b0), .busy(busy0), .done(done0),
        .pass(pass0), .err_count(err0), .fail_vec(fail0)
    );

    and2_bist_ctrl #(.SETTLE_CYC(1)) u_ctrl1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_out(stuck0),
        .dut_a(a1), .dut_b(b1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err1), .fail_vec(fail1)
    );

    int sel;
    logic s_a, s_b, s_busy, s_done, s_pass;
    logic [ERR_W-1:0] s_err;
    logic [N_VEC-1:0] s_fail;

    always_comb begin
        if (sel == 0) begin
            s_a = a0; s_b = b0; s_busy = busy0; s_done = done0;
            s_pass = pass0; s_err = err0; s_fail = fail0;
        end else begin
            s_a = a1; s_b = b1; s_busy = busy1; s_done = done1;
            s_pass = pass1; s_err = err1; s_fail = fail1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run(input int which, input int settle, input int exp_err,
                       input logic [3:0] exp_fail, input logic exp_pass);
        int done_idx, busy_cnt, dones, run_len;
        run_len  = 4 * (settle + 1);
        sel      = which;
        @(negedge clk);
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        done_idx = -1;
        busy_cnt = 0;
        dones    = 0;
        for (int i = 0; i < run_len + 6; i++) begin
            if (i > 0) @(negedge clk);
            if (s_busy) busy_cnt++;
            if (s_done) begin
                dones++;
                if (done_idx < 0) done_idx = i;
            end
            if (i < run_len) chk("vector_order", {30'd0, s_a, s_b}, i / (settle + 1));
        end
        chk("done_latency", done_idx, run_len);
        chk("done_pulses", dones, 1);
        chk("busy_cycles", busy_cnt, run_len);
        chk("err_count", s_err, exp_err);
        chk("fail_vec", s_fail, exp_fail);
        chk("pass", s_pass, exp_pass);
    endtask

    initial begin
        int found;
        int dones;
        int idx[3];
        logic busy13, busy14;

        sel    = 0;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        mode   = 2'd0;
        stuck0 = 1'b0;
        #12;
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_pass", pass0, 0);
        chk("rst_err", err0, 0);
        chk("rst_fail", fail0, 0);
        chk("rst_vec", {a0, b0}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        mode = 2'd0; run(0, 2, 0, 4'b0000, 1'b1);
        mode = 2'd1; run(0, 2, 3, 4'b0111, 1'b0);
        mode = 2'd2; run(0, 2, 2, 4'b0110, 1'b0);

        // Abort during vector 10 with a stuck-at-1 output so counters are nonzero.
        mode = 2'd1;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        found  = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (a0 && !b0) found = 1;
            else @(negedge clk);
        end
        chk("reach_vec10", found, 1);
        chk("pre_rst_err", err0, 2);
        chk("pre_rst_fail", fail0, 4'b0011);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy0, 0);
        chk("abort_done", done0, 0);
        chk("abort_err", err0, 0);
        chk("abort_fail", fail0, 0);
        chk("abort_vec", {a0, b0}, 0);
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done0) dones++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done0) dones++;
        end
        chk("abort_no_done", dones, 0);
        mode = 2'd0; run(0, 2, 0, 4'b0000, 1'b1);

        // Start held high: runs restart only through DONE and one IDLE cycle.
        sel    = 0;
        dones  = 0;
        busy13 = 1'bx;
        busy14 = 1'bx;
        @(negedge clk);
        start0 = 1'b1;
        for (int i = 0; i <= 50; i++) begin
            @(negedge clk);
            if (done0) begin
                if (dones < 3) idx[dones] = i;
                dones++;
            end
            if (i == 13) busy13 = busy0;
            if (i == 14) busy14 = busy0;
            if (i == 38) start0 = 1'b0;
        end
        chk("b2b_runs", dones, 3);
        chk("b2b_first_done", idx[0], 12);
        chk("b2b_gap1", idx[1] - idx[0], 14);
        chk("b2b_gap2", idx[2] - idx[1], 14);
        chk("b2b_idle_gap", busy13, 0);
        chk("b2b_restart", busy14, 1);
        chk("b2b_pass", pass0, 1);

        run(1, 1, 1, 4'b1000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
